pwlock_ctrl: RTL and testbench

- Consumer end of the keypad digit interface: accepts one 2-bit digit per strobe and assembles a 4-digit entry.
- Compares the entry against a stored password and drives lock, alarm and lockout status.
- Supports changing the password while unlocked.
- Sits between the keypad capture logic (digit plus strobe) and the LED/7-segment display logic.

---
 rtl/pwlock_pkg.sv | 20 ++
 rtl/pwlock_ctrl_if.sv | 27 ++
 rtl/pwlock_shift.sv | 45 ++++
 rtl/pwlock_ctrl.sv | 152 +++++++++++++++
 tb/tb_pwlock_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pwlock_pkg.sv
// Shared types and widths for the keypad password lock.
package pwlock_pkg;

  localparam int DIGIT_W = 2;
  localparam int NIB_W   = 4;
  localparam int CODE_W  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER   = 3'd1,
    OPEN    = 3'd2,
    SETPW   = 3'd3,
    LOCKOUT = 3'd4
  } pw_state_e;

  function automatic logic [NIB_W-1:0] pack_digit(input logic [DIGIT_W-1:0] d);
    return {2'b00, d};
  endfunction

endpackage

// File: rtl/pwlock_ctrl_if.sv
// Keypad-side inputs and display-side status of the password lock.
interface pwlock_ctrl_if;
  import pwlock_pkg::*;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               set_req;
  logic               lock_req;
  logic               unlocked;
  logic               alarm;
  logic               set_mode;
  logic [2:0]         entry_cnt;
  logic [CODE_W-1:0]  entry_disp;
  logic [1:0]         fail_cnt;
  logic [2:0]         state_o;

  modport master (
    output key_valid, key_digit, set_req, lock_req,
    input  unlocked, alarm, set_mode, entry_cnt, entry_disp, fail_cnt, state_o
  );

  modport slave (
    input  key_valid, key_digit, set_req, lock_req,
    output unlocked, alarm, set_mode, entry_cnt, entry_disp, fail_cnt, state_o
  );

endinterface

// File: rtl/pwlock_shift.sv
// Four-nibble entry shift register; newest digit lands in bits[3:0].
module pwlock_shift
  import pwlock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_i,
  input  logic               clr_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [CODE_W-1:0]  entry_o,
  output logic [2:0]         cnt_o,
  output logic               done_o
);

  logic [CODE_W-1:0] entry_q, entry_d;
  logic [2:0]        cnt_q, cnt_d;

  // Clear wins over a simultaneous shift; a full entry never shifts further.
  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      entry_d = '0;
      cnt_d   = '0;
    end else if (shift_i && (cnt_q != 3'd4)) begin
      entry_d = {entry_q[CODE_W-NIB_W-1:0], pack_digit(digit_i)};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      cnt_q   <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign entry_o = entry_q;
  assign cnt_o   = cnt_q;
  assign done_o  = (cnt_q == 3'd4);

endmodule

// File: rtl/pwlock_ctrl.sv
// Password lock FSM with lockout timer and in-place password change.
// Optional entry idle timeout enabled by defining PWLOCK_ENTRY_TIMEOUT_EN.
module pwlock_ctrl
  import pwlock_pkg::*;
#(
  parameter int unsigned       MAX_FAIL    = 3,
  parameter logic [31:0]       LOCKOUT_CYC = 32'd100_000_000,
  parameter logic [CODE_W-1:0] DEFAULT_PW  = 16'h0123,
  parameter logic [31:0]       TIMEOUT_CYC = 32'd500_000_000
) (
  input  logic          clk,
  input  logic          rst,
  pwlock_ctrl_if.slave  pw_if
);

  localparam logic [1:0] FAIL_LIM = 2'(MAX_FAIL);

  pw_state_e         state_q, state_d;
  logic [CODE_W-1:0] pw_q, pw_d;
  logic [1:0]        fail_q, fail_d;
  logic [31:0]       lock_cnt_q, lock_cnt_d;

  logic              shift_en;
  logic              entry_clr;
  logic              entry_done;
  logic              timeout;
  logic [CODE_W-1:0] entry;
  logic [2:0]        entry_cnt;

  pwlock_shift u_shift (
    .clk     (clk),
    .rst     (rst),
    .shift_i (shift_en),
    .clr_i   (entry_clr),
    .digit_i (pw_if.key_digit),
    .entry_o (entry),
    .cnt_o   (entry_cnt),
    .done_o  (entry_done)
  );

`ifdef PWLOCK_ENTRY_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        in_entry;

  assign in_entry = (state_q == ENTER) || (state_q == SETPW);

  always_comb begin
    idle_d = idle_q + 32'd1;
    if (pw_if.key_valid || !in_entry) idle_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end

  assign timeout = in_entry && !pw_if.key_valid && !entry_done &&
                   (idle_q == TIMEOUT_CYC - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout        = 1'b0;
`endif

  // The cycle after the fourth digit lands is the compare cycle; strobes then are dropped.
  always_comb begin
    state_d    = state_q;
    pw_d       = pw_q;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;
    entry_clr  = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        shift_en = pw_if.key_valid;
        if (pw_if.key_valid) state_d = ENTER;
      end
      ENTER: begin
        if (entry_done) begin
          entry_clr = 1'b1;
          if (entry == pw_q) begin
            state_d = OPEN;
            fail_d  = '0;
          end else if (fail_q + 2'd1 == FAIL_LIM) begin
            state_d    = LOCKOUT;
            fail_d     = FAIL_LIM;
            lock_cnt_d = LOCKOUT_CYC - 32'd1;
          end else begin
            state_d = IDLE;
            fail_d  = fail_q + 2'd1;
          end
        end else if (timeout) begin
          entry_clr = 1'b1;
          state_d   = IDLE;
        end else begin
          shift_en = pw_if.key_valid;
        end
      end
      OPEN: begin
        if (pw_if.lock_req)     state_d = IDLE;
        else if (pw_if.set_req) state_d = SETPW;
      end
      SETPW: begin
        if (pw_if.lock_req) begin
          entry_clr = 1'b1;
          state_d   = IDLE;
        end else if (entry_done) begin
          pw_d      = entry;
          entry_clr = 1'b1;
          state_d   = OPEN;
        end else if (timeout) begin
          entry_clr = 1'b1;
          state_d   = OPEN;
        end else begin
          shift_en = pw_if.key_valid;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_q == 32'd0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pw_q       <= DEFAULT_PW;
      fail_q     <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pw_q       <= pw_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign pw_if.unlocked   = (state_q == OPEN) || (state_q == SETPW);
  assign pw_if.alarm      = (state_q == LOCKOUT);
  assign pw_if.set_mode   = (state_q == SETPW);
  assign pw_if.entry_cnt  = entry_cnt;
  assign pw_if.entry_disp = entry;
  assign pw_if.fail_cnt   = fail_q;
  assign pw_if.state_o    = state_q;

endmodule

// File: tb/tb_pwlock_ctrl.sv
// Directed self-checking bench for pwlock_ctrl (short lockout and timeout).
module tb_pwlock_ctrl;
  import pwlock_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   failCount  = 0;
  int   alarmCycles;

  pwlock_ctrl_if pwIf ();

  pwlock_ctrl #(
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (32'd10),
    .DEFAULT_PW  (16'h0123),
    .TIMEOUT_CYC (32'd20)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pw_if (pwIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of inputs; returns just after the edge that sampled them.
  task automatic applyStimulus(input logic kv, input logic [1:0] d, input logic s, input logic l);
    pwIf.key_valid = kv;
    pwIf.key_digit = d;
    pwIf.set_req   = s;
    pwIf.lock_req  = l;
    @(posedge clk);
    #1;
    pwIf.key_valid = 1'b0;
    pwIf.key_digit = 2'd0;
    pwIf.set_req   = 1'b0;
    pwIf.lock_req  = 1'b0;
  endtask

  task automatic enterCode(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] e);
    applyStimulus(1'b1, a, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0);
    applyStimulus(1'b1, c, 1'b0, 1'b0);
    applyStimulus(1'b1, e, 1'b0, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pwIf.key_valid = 1'b0;
    pwIf.key_digit = 2'd0;
    pwIf.set_req   = 1'b0;
    pwIf.lock_req  = 1'b0;
    #12;
    checkOutput("rst_state", 32'(pwIf.state_o), 32'd0);
    checkOutput("rst_unlocked", 32'(pwIf.unlocked), 32'd0);
    checkOutput("rst_entry_disp", 32'(pwIf.entry_disp), 32'd0);
    checkOutput("rst_fail", 32'(pwIf.fail_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Default code unlocks two cycles after the fourth strobe
    enterCode(2'd0, 2'd1, 2'd2, 2'd3);
    checkOutput("t1_cnt4", 32'(pwIf.entry_cnt), 32'd4);
    checkOutput("t1_disp", 32'(pwIf.entry_disp), 32'h0123);
    checkOutput("t1_not_yet", 32'(pwIf.unlocked), 32'd0);
    idleCycle();
    checkOutput("t1_unlocked", 32'(pwIf.unlocked), 32'd1);
    checkOutput("t1_state", 32'(pwIf.state_o), 32'd2);
    checkOutput("t1_fail", 32'(pwIf.fail_cnt), 32'd0);
    checkOutput("t1_disp_clr", 32'(pwIf.entry_disp), 32'd0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    checkOutput("t1_open_ignore", 32'(pwIf.entry_cnt), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t1_relock", 32'(pwIf.state_o), 32'd0);

    // Wrong codes escalate to a ten-cycle lockout
    for (int f = 1; f <= 2; f++) begin
      enterCode(2'd3, 2'd3, 2'd3, 2'd3);
      checkOutput("t2_disp3333", 32'(pwIf.entry_disp), 32'h3333);
      idleCycle();
      checkOutput("t2_fail", 32'(pwIf.fail_cnt), 32'(f));
      checkOutput("t2_idle", 32'(pwIf.state_o), 32'd0);
    end
    enterCode(2'd3, 2'd3, 2'd3, 2'd3);
    idleCycle();
    checkOutput("t2_alarm", 32'(pwIf.alarm), 32'd1);
    checkOutput("t2_fail3", 32'(pwIf.fail_cnt), 32'd3);
    checkOutput("t2_state_lock", 32'(pwIf.state_o), 32'd4);
    alarmCycles = 0;
    while (pwIf.alarm && alarmCycles < 50) begin
      alarmCycles++;
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    end
    checkOutput("t2_alarm_len", 32'(alarmCycles), 32'd10);
    checkOutput("t2_post_state", 32'(pwIf.state_o), 32'd0);
    checkOutput("t2_post_fail", 32'(pwIf.fail_cnt), 32'd0);
    checkOutput("t2_post_cnt", 32'(pwIf.entry_cnt), 32'd0);

    // Change password to 2,2,1,0 then relock
    enterCode(2'd0, 2'd1, 2'd2, 2'd3);
    idleCycle();
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("t3_set_mode", 32'(pwIf.set_mode), 32'd1);
    checkOutput("t3_unlocked", 32'(pwIf.unlocked), 32'd1);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    checkOutput("t3_cnt2", 32'(pwIf.entry_cnt), 32'd2);
    checkOutput("t3_set_mode_mid", 32'(pwIf.set_mode), 32'd1);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("t3_disp", 32'(pwIf.entry_disp), 32'h2210);
    idleCycle();
    checkOutput("t3_back_open", 32'(pwIf.state_o), 32'd2);
    checkOutput("t3_set_mode_off", 32'(pwIf.set_mode), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    enterCode(2'd0, 2'd1, 2'd2, 2'd3);
    idleCycle();
    checkOutput("t3_old_fails", 32'(pwIf.fail_cnt), 32'd1);
    checkOutput("t3_old_locked", 32'(pwIf.unlocked), 32'd0);
    enterCode(2'd2, 2'd2, 2'd1, 2'd0);
    idleCycle();
    checkOutput("t3_new_opens", 32'(pwIf.unlocked), 32'd1);
    checkOutput("t3_fail_clr", 32'(pwIf.fail_cnt), 32'd0);

    // Simultaneous set/lock, then abandoned password change
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("t4_lock_wins", 32'(pwIf.state_o), 32'd0);
    checkOutput("t4_no_set_mode", 32'(pwIf.set_mode), 32'd0);
    enterCode(2'd2, 2'd2, 2'd1, 2'd0);
    idleCycle();
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t4_abort_state", 32'(pwIf.state_o), 32'd0);
    checkOutput("t4_abort_cnt", 32'(pwIf.entry_cnt), 32'd0);
    enterCode(2'd2, 2'd2, 2'd1, 2'd0);
    idleCycle();
    checkOutput("t4_old_pw_kept", 32'(pwIf.unlocked), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-entry restores the default password
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    checkOutput("t5_cnt2", 32'(pwIf.entry_cnt), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_cnt", 32'(pwIf.entry_cnt), 32'd0);
    checkOutput("t5_rst_state", 32'(pwIf.state_o), 32'd0);
    checkOutput("t5_rst_disp", 32'(pwIf.entry_disp), 32'd0);
    rst = 1'b0;
    enterCode(2'd0, 2'd1, 2'd2, 2'd3);
    idleCycle();
    checkOutput("t5_default_pw", 32'(pwIf.unlocked), 32'd1);

    // Reset during lockout after another password change
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    enterCode(2'd2, 2'd2, 2'd1, 2'd0);
    idleCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      enterCode(2'd3, 2'd3, 2'd3, 2'd3);
      idleCycle();
    end
    checkOutput("t5_lockout", 32'(pwIf.alarm), 32'd1);
    idleCycle();
    idleCycle();
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_alarm", 32'(pwIf.alarm), 32'd0);
    checkOutput("t5_rst_fail", 32'(pwIf.fail_cnt), 32'd0);
    checkOutput("t5_rst_state2", 32'(pwIf.state_o), 32'd0);
    rst = 1'b0;
    enterCode(2'd0, 2'd1, 2'd2, 2'd3);
    idleCycle();
    checkOutput("t5_revert_pw", 32'(pwIf.unlocked), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);

`ifdef PWLOCK_ENTRY_TIMEOUT_EN
    // Partial entry is discarded after twenty quiet cycles
    enterCode(2'd3, 2'd3, 2'd3, 2'd3);
    idleCycle();
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 19; k++) idleCycle();
    checkOutput("t6_still_cnt", 32'(pwIf.entry_cnt), 32'd2);
    idleCycle();
    checkOutput("t6_to_cnt", 32'(pwIf.entry_cnt), 32'd0);
    checkOutput("t6_to_state", 32'(pwIf.state_o), 32'd0);
    checkOutput("t6_to_fail", 32'(pwIf.fail_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
